// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire receiver. Synchronizes din, measures high and low
// pulse widths, decodes GRB pixels MSB first, and detects the latch/reset low period.
// Optional chain-node forwarding is enabled by defining WS2812_RX_FORWARD_EN:
// the first pixel of each frame is decoded and the rest of the frame is forwarded on dout.
module ws2812_rx #(
    parameter int unsigned BIT_THRESH   = 6,
    parameter int unsigned MAX_HIGH     = 20,
    parameter int unsigned RESET_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       pixel_valid,
    output logic       frame_reset,
    output logic       err,
    output logic       dout
);

    localparam int unsigned HW = $clog2(MAX_HIGH + 1);
    localparam int unsigned LW = $clog2(RESET_CYCLES + 1);
    localparam logic [HW-1:0] HMax   = HW'(MAX_HIGH);
    localparam logic [HW-1:0] HMaxM1 = HW'(MAX_HIGH - 1);
    localparam logic [HW-1:0] HThr   = HW'(BIT_THRESH);
    localparam logic [LW-1:0] LMax   = LW'(RESET_CYCLES);
    localparam logic [LW-1:0] LMaxM1 = LW'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        StWaitReset,
        StReady,
        StHigh,
        StLow
`ifdef WS2812_RX_FORWARD_EN
        , StPass
`endif
    } state_e;

    state_e        state_q, state_d;
    logic          s1_q, s1_d, s2_q, s2_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [4:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic          pv_q, pv_d, fr_q, fr_d, err_q, err_d, dout_q, dout_d;
    logic          h_hit, l_hit, bit_val;

    // Next-state logic: synchronizer, pulse-width counters and decode FSM.
    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        hcnt_d = s2_q ? ((hcnt_q == HMax) ? hcnt_q : hcnt_q + 1'b1) : '0;
        lcnt_d = s2_q ? '0 : ((lcnt_q == LMax) ? lcnt_q : lcnt_q + 1'b1);
        // Hits fire only on the edge where the counter first reaches its limit.
        h_hit   = s2_q && (hcnt_q == HMaxM1);
        l_hit   = !s2_q && (lcnt_q == LMaxM1);
        bit_val = (hcnt_q >= HThr);

        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        r_d      = r_q;
        g_d      = g_q;
        b_d      = b_q;
        pv_d     = 1'b0;
        fr_d     = 1'b0;
        err_d    = 1'b0;
        dout_d   = 1'b0;

        unique case (state_q)
            StWaitReset: begin
                if (l_hit) begin
                    fr_d     = 1'b1;
                    bitcnt_d = '0;
                    state_d  = StReady;
                end
            end
            StReady: begin
                if (s2_q) state_d = StHigh;
            end
            StHigh: begin
                if (!s2_q) begin
                    shift_d = {shift_q[22:0], bit_val};
                    if (bitcnt_q == 5'd23) begin
                        g_d      = shift_q[22:15];
                        r_d      = shift_q[14:7];
                        b_d      = {shift_q[6:0], bit_val};
                        pv_d     = 1'b1;
                        bitcnt_d = '0;
`ifdef WS2812_RX_FORWARD_EN
                        state_d  = StPass;
`else
                        state_d  = StLow;
`endif
                    end else begin
                        bitcnt_d = bitcnt_q + 5'd1;
                        state_d  = StLow;
                    end
                end else if (h_hit) begin
                    err_d    = 1'b1;
                    bitcnt_d = '0;
                    state_d  = StWaitReset;
                end
            end
            StLow: begin
                if (s2_q) begin
                    state_d = StHigh;
                end else if (l_hit) begin
                    // A latch in mid-pixel drops the partial pixel and flags it.
                    fr_d     = 1'b1;
                    err_d    = (bitcnt_q != 5'd0);
                    bitcnt_d = '0;
                    state_d  = StReady;
                end
            end
`ifdef WS2812_RX_FORWARD_EN
            StPass: begin
                dout_d = s2_q;
                if (h_hit) begin
                    err_d   = 1'b1;
                    state_d = StWaitReset;
                end else if (l_hit) begin
                    fr_d    = 1'b1;
                    state_d = StReady;
                end
            end
`endif
            default: state_d = StWaitReset;
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StWaitReset;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            hcnt_q   <= '0;
            lcnt_q   <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            pv_q     <= 1'b0;
            fr_q     <= 1'b0;
            err_q    <= 1'b0;
            dout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            hcnt_q   <= hcnt_d;
            lcnt_q   <= lcnt_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            pv_q     <= pv_d;
            fr_q     <= fr_d;
            err_q    <= err_d;
            dout_q   <= dout_d;
        end
    end

    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign pixel_valid = pv_q;
    assign frame_reset = fr_q;
    assign err         = err_q;
    assign dout        = dout_q;

endmodule
